// File: rtl/board_loader.sv
// board_loader: copies one board image from the board ROM into object memory.
// On an accepted start it requests the object memory from the arbiter. Once
// granted, it streams BOARD_CELLS bytes from ROM, starting at
// board_sel*BOARD_STRIDE, and decodes each byte into an object word. It ends
// the load with a done pulse, or with an abort pulse if the grant is lost.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, board_sel    one-cycle load request and the board index it carries
//   req, grant          ownership handshake with the game arbiter
//   rom_addr, rom_data  board ROM read port; the ROM has a one-cycle read latency
//   om_addr/data/wren   object memory write port
//   busy                high while a load is in progress
//   done, abort, err    one-cycle status pulses
//   checksum            sum of the words written in the current load (optional)
//
// Optional feature: define BOARD_LOADER_CHECKSUM_EN to add the checksum output.
module board_loader #(
    parameter int unsigned NUM_BOARDS   = 8,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned BOARD_CELLS  = 105,
    parameter int unsigned BOARD_STRIDE = 128,
    parameter int unsigned ROM_AW       = 10,
    parameter int unsigned OM_AW        = 7,
    parameter int unsigned DATA_W       = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  board_sel,
    output logic              req,
    input  logic              grant,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [OM_AW-1:0]  om_addr,
    output logic [DATA_W-1:0] om_data,
    output logic              om_wren,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic              err
`ifdef BOARD_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned CNT_W = $clog2(BOARD_CELLS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_PRIME, S_COPY} state_t;

    state_t              state_q, state_d;
    logic [ROM_AW-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [OM_AW-1:0]    om_addr_q, om_addr_d;
    logic [DATA_W-1:0]   om_data_q, om_data_d;
    logic                om_wren_q, om_wren_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   word_dec;

    // Packed byte -> object word: bit 7 set selects a 7-bit literal, clear
    // selects a 3-bit type code placed in the top bits.
    function automatic logic [DATA_W-1:0] decode(input logic [7:0] b);
        logic [DATA_W-1:0] w;
        w = '0;
        if (b[7]) begin
            w[6:0] = b[6:0];
        end else begin
            w[DATA_W-1 -: 3] = b[2:0];
        end
        return w;
    endfunction

    assign word_dec = decode(rom_data);

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        om_addr_d  = om_addr_q;
        om_data_d  = om_data_q;
        om_wren_d  = 1'b0;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (32'(board_sel) < NUM_BOARDS) begin
                        base_d  = ROM_AW'(32'(board_sel) * BOARD_STRIDE);
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_REQUEST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQUEST: begin
                if (grant) begin
                    rom_addr_d = base_q;
                    state_d    = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!grant) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rom_addr_d = base_q + ROM_AW'(1);
                    cnt_d      = '0;
                    state_d    = S_COPY;
                end
            end
            S_COPY: begin
                // A full count means every word is written; finish even if
                // the grant drops in this last cycle.
                if (cnt_q == CNT_W'(BOARD_CELLS)) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!grant) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    om_wren_d  = 1'b1;
                    om_addr_d  = OM_AW'(cnt_q);
                    om_data_d  = word_dec;
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            om_addr_q  <= '0;
            om_data_q  <= '0;
            om_wren_q  <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            om_addr_q  <= om_addr_d;
            om_data_q  <= om_data_d;
            om_wren_q  <= om_wren_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

`ifdef BOARD_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Running sum of written words; cleared on an accepted start, held otherwise
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && state_d == S_REQUEST) begin
            checksum_d = '0;
        end else if (om_wren_d) begin
            checksum_d = checksum_q + om_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign req      = req_q;
    assign rom_addr = rom_addr_q;
    assign om_addr  = om_addr_q;
    assign om_data  = om_data_q;
    assign om_wren  = om_wren_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign err      = err_q;

endmodule

// File: tb/tb_board_loader.sv
// Scoreboard bench for board_loader (NUM_BOARDS=5, other parameters default).
// Test sequences push expected writes and pulses, each with its cycle, into
// queues. A negedge monitor pops an entry and compares it whenever the DUT
// shows an output.
module tb_board_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  board_sel;
    logic        req;
    logic        grant;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [6:0]  om_addr;
    logic [10:0] om_data;
    logic        om_wren;
    logic        busy;
    logic        done;
    logic        abort;
    logic        err;
`ifdef BOARD_LOADER_CHECKSUM_EN
    logic [10:0] checksum;
`endif

    board_loader #(.NUM_BOARDS(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .board_sel(board_sel),
        .req      (req),
        .grant    (grant),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .om_addr  (om_addr),
        .om_data  (om_data),
        .om_wren  (om_wren),
        .busy     (busy),
        .done     (done),
        .abort    (abort),
        .err      (err)
`ifdef BOARD_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    typedef struct {int cyc; int addr; int data;} wr_t;
    typedef struct {int cyc; int sum;} done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    exp_abort[$];
    int    exp_err[$];

    logic [7:0] rom [1024];
    int cyc;
    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int ref_dec(input logic [7:0] b);
        logic [10:0] w;
        if (b[7]) w = {4'b0000, b[6:0]};
        else      w = {b[2:0], 8'h00};
        return int'(w);
    endfunction

    // Queue n writes of board sel starting at cycle c_wr, plus a done at
    // c_done (skipped when c_done < 0).
    task automatic push_load(input int sel, input int c_wr, input int n, input int c_done);
        int sum;
        wr_t e;
        done_t d;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            e.cyc  = c_wr + i;
            e.addr = i;
            e.data = ref_dec(rom[sel * 128 + i]);
            sum    = (sum + e.data) % 2048;
            exp_wr.push_back(e);
        end
        if (c_done >= 0) begin
            d.cyc = c_done;
            d.sum = sum;
            exp_done.push_back(d);
        end
    endtask

    // Returns the monitor cycle number right after the start edge.
    task automatic do_start(input int sel, output int c0);
        @(negedge clk);
        start     = 1'b1;
        board_sel = 3'(sel);
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
    endtask

    // Monitor
    wr_t   mw;
    done_t md;
    int    mi;
    always @(negedge clk) begin
        if (rst_n) begin
            if (om_wren) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    mw = exp_wr.pop_front();
                    chk("wr_cyc", cyc, mw.cyc);
                    chk("wr_addr", int'(om_addr), mw.addr);
                    chk("wr_data", int'(om_data), mw.data);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    md = exp_done.pop_front();
                    chk("done_cyc", cyc, md.cyc);
                    chk("done_busy", int'(busy), 0);
`ifdef BOARD_LOADER_CHECKSUM_EN
                    chk("checksum", int'(checksum), md.sum);
`endif
                end
            end
            if (abort) begin
                if (exp_abort.size() == 0) chk("unexpected_abort", 1, 0);
                else begin
                    mi = exp_abort.pop_front();
                    chk("abort_cyc", cyc, mi);
                    chk("abort_wren", int'(om_wren), 0);
                end
            end
            if (err) begin
                if (exp_err.size() == 0) chk("unexpected_err", 1, 0);
                else begin
                    mi = exp_err.pop_front();
                    chk("err_cyc", cyc, mi);
                    chk("err_req", int'(req), 0);
                end
            end
            if (done | abort | err)
                chk("pulse_excl", int'(done) + int'(abort) + int'(err), 1);
        end
    end

    initial begin
        int c0;
        int c1;
        for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 73 + 11) ^ (i >> 3));
        rom[256] = 8'h85;
        rom[257] = 8'h03;
        rom[258] = 8'h7F;
        cyc = 0; n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; grant = 1'b1; board_sel = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wren", int'(om_wren), 0);
        chk("rst_pulses", int'(done) + int'(abort) + int'(err), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_om_addr", int'(om_addr), 0);
        chk("rst_om_data", int'(om_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal load of board 2, including the hand-decoded first bytes
        do_start(2, c0);
        push_load(2, c0 + 3, 105, c0 + 108);
        exp_wr[0].data = 'h005;
        exp_wr[1].data = 'h300;
        exp_wr[2].data = 'h700;
        chk("nom_busy", int'(busy), 1);
        @(negedge clk);
        chk("nom_rom_addr0", int'(rom_addr), 256);
        @(negedge clk);
        chk("nom_rom_addr1", int'(rom_addr), 257);
        repeat (110) @(negedge clk);

        // Arbitration wait: grant low for 10 cycles after start
        grant = 1'b0;
        do_start(3, c0);
        push_load(3, c0 + 13, 105, c0 + 118);
        for (int k = 0; k < 10; k++) begin
            chk("wait_req", int'(req), 1);
            chk("wait_busy", int'(busy), 1);
            @(negedge clk);
        end
        grant = 1'b1;
        repeat (112) @(negedge clk);

        // Abort after the 40th write, then a clean load of board 0
        do_start(1, c0);
        push_load(1, c0 + 3, 40, -1);
        exp_abort.push_back(c0 + 43);
        repeat (42) @(negedge clk);
        grant = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_req", int'(req), 0);
        grant = 1'b1;
        repeat (5) @(negedge clk);
        do_start(0, c0);
        push_load(0, c0 + 3, 105, c0 + 108);
        repeat (110) @(negedge clk);

        // Out-of-range selects, at the boundary and beyond
        do_start(6, c0);
        exp_err.push_back(c0);
        repeat (3) @(negedge clk);
        chk("err6_busy", int'(busy), 0);
        do_start(5, c0);
        exp_err.push_back(c0);
        repeat (3) @(negedge clk);
        chk("err5_req", int'(req), 0);

        // Start while busy is ignored
        do_start(3, c0);
        push_load(3, c0 + 3, 105, c0 + 108);
        repeat (20) @(negedge clk);
        do_start(4, c1);
        repeat (95) @(negedge clk);

        // Asynchronous reset mid-copy
        do_start(4, c0);
        push_load(4, c0 + 3, 20, -1);
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wren", int'(om_wren), 0);
        chk("arst_req", int'(req), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);

        chk("left_writes", exp_wr.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("left_abort", exp_abort.size(), 0);
        chk("left_err", exp_err.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_loader.md
Name: board_loader

Overview:
- Parametrised successor of the new-game board copy logic.
- On a start request, asks the game arbiter for ownership of the object memory, then streams one selected board image from the board ROM into object memory.
- Decodes each packed ROM byte into an object word, then reports completion.
- Supports any board count, board size and stride, abort on grant loss, and select-range checking.

Parameters:
- NUM_BOARDS, 8, number of board images in ROM
- SEL_W, 3, width of board_sel
- BOARD_CELLS, 105, words copied per board (object addresses 0..BOARD_CELLS-1)
- BOARD_STRIDE, 128, ROM words between consecutive board base addresses
- ROM_AW, 10, board ROM address width
- OM_AW, 7, object memory address width
- DATA_W, 11, object memory data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle load request
- board_sel  in  SEL_W  board index, sampled with start
- req  out  1  ownership request to arbiter, level
- grant  in  1  arbiter grant; must stay high for the whole copy
- rom_addr  out  ROM_AW  board ROM read address
- rom_data  in  8  ROM byte, valid one cycle after rom_addr (registered read)
- om_addr  out  OM_AW  object memory write address
- om_data  out  DATA_W  object memory write data
- om_wren  out  1  object memory write enable
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse: board fully written
- abort  out  1  one-cycle pulse: grant lost mid-copy
- err  out  1  one-cycle pulse: start rejected because board_sel >= NUM_BOARDS

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req, busy, om_wren, done, abort, err = 0; rom_addr, om_addr, om_data = 0.
- States: IDLE, REQUEST, PRIME, COPY.
- IDLE:
  - start with board_sel < NUM_BOARDS: latch base = board_sel*BOARD_STRIDE (ROM_AW bits); req=1, busy=1; go to REQUEST.
  - start with board_sel >= NUM_BOARDS: err=1 for one cycle; stay in IDLE.
- REQUEST: hold req=1. On grant=1, drive rom_addr=base and go to PRIME.
- PRIME: rom_addr=base+1; no write.
- COPY, index i = 0..BOARD_CELLS-1, one word per cycle:
  - om_wren=1, om_addr=i, om_data=decode(byte fetched for base+i).
  - rom_addr stays one address ahead of the write.
- Write count: exactly BOARD_CELLS consecutive om_wren cycles.
- End of copy: the cycle after the last write, om_wren=0, req=0, busy=0, done=1, state=IDLE.
- Latency: with grant already high, the first write occurs 3 cycles after start; done asserts BOARD_CELLS+3 cycles after start.
- decode(b):
  - b[7]=1: zero-extend b[6:0] to DATA_W.
  - b[7]=0: b[2:0] placed at bits [10:8], lower bits 0 (for DATA_W=11; generally at bits DATA_W-1:DATA_W-3).
- Grant loss: grant=0 in PRIME or COPY ends the load that cycle.
  - om_wren=0, req=0, busy=0, abort=1, no done, state=IDLE.
  - Words already written remain written.
- Ignored inputs: start while busy is ignored; board_sel is sampled only on an accepted start.
- Address arithmetic: rom_addr wraps modulo 2^ROM_AW; om_addr never exceeds BOARD_CELLS-1.
- Reset mid-copy: all outputs return to reset values immediately; no done or abort pulse.
- Pulse exclusivity: done, abort and err never assert in the same cycle.

Optional Feature:
- Macro: BOARD_LOADER_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W-1:0], the sum of all om_data values written during the load, modulo 2^DATA_W.
  - Cleared on accepted start.
  - Valid and stable from the done pulse until the next accepted start.
  - On abort it holds the partial sum.
- Undefined: port absent, no adder.

Test Plan:
- Nominal load: grant tied high, start with board_sel=2 -> first rom_addr=256; 105 om_wren pulses at om_addr 0..104; done exactly once, 108 cycles after start.
- Decode: ROM byte 0x85 -> om_data=0x005; byte 0x03 -> om_data=0x300; byte 0x7F -> om_data=0x700.
- Arbitration wait: grant held low 10 cycles after start -> req=1 and busy=1 throughout, no writes; grant high -> normal copy; done 10 cycles later than in the nominal load.
- Abort: drop grant after the 40th write -> abort pulse; om_wren low in the same cycle; busy=0; no done; next start with board_sel=0 completes normally.
- Bad select with NUM_BOARDS=5: start with board_sel=6 -> err pulse, req stays 0, no writes. Start while busy -> ignored, exactly one done.
- Async reset: assert rst_n=0 mid-COPY between clock edges -> om_wren, req and busy drop to 0 immediately; no done after release. With BOARD_LOADER_CHECKSUM_EN defined, checksum equals the bench's reference sum at done.
